// File: rtl/vram_wr_queue.sv
// vram_wr_queue: write buffer between the rasteriser VRAM port and an acking VRAM.
// Requests are queued in a DEPTH-entry FIFO and issued downstream one at a time,
// with each one held stable until vram_ack_i.
// Optional build macro VRAM_WR_MERGE_EN: a write to the same address as the
// queued tail write is folded into that entry instead of taking a new slot.
module vram_wr_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset_ni,
    input  logic                         up_sel_i,
    input  logic                         up_wr_i,
    input  logic [MASK_WIDTH-1:0]        up_mask_i,
    input  logic [ADDR_WIDTH-1:0]        up_addr_i,
    input  logic [DATA_WIDTH-1:0]        up_data_i,
    output logic                         up_ready_o,
    output logic                         vram_sel_o,
    output logic                         vram_wr_o,
    output logic [MASK_WIDTH-1:0]        vram_mask_o,
    output logic [ADDR_WIDTH-1:0]        vram_addr_o,
    output logic [DATA_WIDTH-1:0]        vram_data_out_o,
    input  logic                         vram_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         empty_o
);
    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic                  wr;
        logic [MASK_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    typedef enum logic {IDLE, REQ} state_t;

    req_t          mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    state_t        state;
    req_t          up_req, head;
    logic          push, pop, merge_hit;

    assign up_req = '{up_wr_i, up_mask_i, up_addr_i, up_data_i};
    assign head   = mem[rptr];

    // The FSM takes the head whenever it is idle, or when the current request is acked.
    assign pop = (count != '0) && ((state == IDLE) || vram_ack_i);

`ifdef VRAM_WR_MERGE_EN
    logic [PW-1:0] tail_ptr;
    req_t          tail, merged;

    assign tail_ptr = wptr - PW'(1);
    assign tail     = mem[tail_ptr];

    // With a single entry queued the tail is also the head; never merge into
    // an entry that is leaving the FIFO on this edge.
    assign merge_hit = up_sel_i && up_wr_i && (count != '0)
                     && !(pop && (count == CW'(1)))
                     && tail.wr && (tail.addr == up_addr_i);

    // Lane-wise overlay of the new write onto the tail entry.
    always_comb begin
        merged      = tail;
        merged.mask = tail.mask | up_mask_i;
        for (int i = 0; i < MASK_WIDTH; i++)
            if (up_mask_i[i])
                merged.data[i*LANE_W +: LANE_W] = up_data_i[i*LANE_W +: LANE_W];
    end

    assign up_ready_o = (count < FULL) || merge_hit;
`else
    assign merge_hit  = 1'b0;
    assign up_ready_o = (count < FULL);
`endif

    assign push    = up_sel_i && up_ready_o && !merge_hit;
    assign level_o = count;
    assign empty_o = (count == '0) && !vram_sel_o;

    // Entry storage: push appends at wptr; a merge rewrites the tail in place.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= up_req;
`ifdef VRAM_WR_MERGE_EN
        else if (merge_hit)
            mem[tail_ptr] <= merged;
`endif
    end

    // Pointers wrap naturally (DEPTH is a power of two); count never over/underflows.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Issue FSM: output registers hold a request until acked; reset drops it outright.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state           <= IDLE;
            vram_sel_o      <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_mask_o     <= '0;
            vram_addr_o     <= '0;
            vram_data_out_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        vram_sel_o      <= 1'b1;
                        vram_wr_o       <= head.wr;
                        vram_mask_o     <= head.mask;
                        vram_addr_o     <= head.addr;
                        vram_data_out_o <= head.data;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (vram_ack_i) begin
                        if (count != '0) begin
                            vram_wr_o       <= head.wr;
                            vram_mask_o     <= head.mask;
                            vram_addr_o     <= head.addr;
                            vram_data_out_o <= head.data;
                        end else begin
                            vram_sel_o <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_wr_queue.sv
// Directed bench for vram_wr_queue: single write, backpressure, ack stall,
// push/pop at fixed level, pointer wrap, reset mid-request and tail merging.
module tb_vram_wr_queue;
    logic        clk;
    logic        reset_ni;
    logic        up_sel, up_wr, up_ready;
    logic [3:0]  up_mask;
    logic [15:0] up_addr, up_data;
    logic        vram_sel, vram_wr, vram_ack, empty;
    logic [3:0]  vram_mask;
    logic [15:0] vram_addr, vram_data;
    logic [3:0]  level;

    int vecs = 0;
    int errs = 0;

    vram_wr_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .reset_ni(reset_ni),
        .up_sel_i(up_sel), .up_wr_i(up_wr), .up_mask_i(up_mask),
        .up_addr_i(up_addr), .up_data_i(up_data), .up_ready_o(up_ready),
        .vram_sel_o(vram_sel), .vram_wr_o(vram_wr), .vram_mask_o(vram_mask),
        .vram_addr_o(vram_addr), .vram_data_out_o(vram_data),
        .vram_ack_i(vram_ack), .level_o(level), .empty_o(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic w, input logic [3:0] m, input logic [15:0] a, input logic [15:0] d);
        up_sel = 1'b1; up_wr = w; up_mask = m; up_addr = a; up_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0; up_sel = 1'b0; up_wr = 1'b0; up_mask = '0;
        up_addr = '0; up_data = '0; vram_ack = 1'b0;
        #2;
        chk("rst_ready", up_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_sel", vram_sel, 0);
        chk("rst_level", level, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_data", vram_data, 0);
        chk("rst_mask", vram_mask, 0);
        chk("rst_wr", vram_wr, 0);
        step();
        reset_ni = 1'b1;
        step();

        // Single write, ack held high
        vram_ack = 1'b1;
        offer(1'b1, 4'hF, 16'h0010, 16'hABCD);
        step();
        up_sel = 1'b0;
        chk("sw_sel_e0", vram_sel, 0);
        chk("sw_level_e0", level, 1);
        chk("sw_empty_e0", empty, 0);
        step();
        chk("sw_sel_e1", vram_sel, 1);
        chk("sw_addr", vram_addr, 16'h0010);
        chk("sw_data", vram_data, 16'hABCD);
        chk("sw_mask", vram_mask, 4'hF);
        chk("sw_wr", vram_wr, 1);
        step();
        chk("sw_sel_e2", vram_sel, 0);
        chk("sw_empty_e2", empty, 1);

        // Backpressure: 9 writes with ack low
        vram_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            offer(1'b1, 4'hF, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
            step();
        end
        chk("bp_level", level, 8);
        chk("bp_ready", up_ready, 0);
        chk("bp_sel", vram_sel, 1);
        chk("bp_head", vram_addr, 16'h0100);
        offer(1'b1, 4'hF, 16'h01FF, 16'h1FFF);
        step();
        chk("bp_full_hold", level, 8);
        up_sel = 1'b0;
        vram_ack = 1'b1;
        for (int i = 1; i < 9; i++) begin
            step();
            chk("bp_order_addr", vram_addr, 32'h0100 + i);
            chk("bp_order_data", vram_data, 32'h1000 + i);
            chk("bp_order_sel", vram_sel, 1);
        end
        step();
        chk("bp_drain_sel", vram_sel, 0);
        chk("bp_drain_empty", empty, 1);

        // Ack stall on 0x1234
        vram_ack = 1'b0;
        offer(1'b1, 4'hF, 16'h1234, 16'h5555);
        step();
        offer(1'b1, 4'h5, 16'h2222, 16'h6666);
        step();
        up_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("st_addr", vram_addr, 16'h1234);
            chk("st_data", vram_data, 16'h5555);
            chk("st_sel", vram_sel, 1);
            step();
        end
        chk("st_addr_last", vram_addr, 16'h1234);
        vram_ack = 1'b1;
        step();
        chk("st_next_addr", vram_addr, 16'h2222);
        chk("st_next_mask", vram_mask, 4'h5);
        step();
        chk("st_done_sel", vram_sel, 0);

        // Push and pop on the same edge at level 3
        vram_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 4'hF, 16'h0200 + 16'(i), 16'h2000 + 16'(i));
            step();
        end
        chk("pp_level_pre", level, 3);
        vram_ack = 1'b1;
        offer(1'b0, 4'hF, 16'h0204, 16'h2004);
        step();
        up_sel = 1'b0;
        chk("pp_level", level, 3);
        chk("pp_addr1", vram_addr, 16'h0201);
        step(); chk("pp_addr2", vram_addr, 16'h0202);
        step(); chk("pp_addr3", vram_addr, 16'h0203);
        step(); chk("pp_addr4", vram_addr, 16'h0204);
        chk("pp_read_flag", vram_wr, 0);
        step(); chk("pp_idle", vram_sel, 0);

        // 20 back-to-back writes, ack high: pointers wrap, order must hold
        for (int i = 0; i < 21; i++) begin
            if (i < 20) offer(1'b1, 4'hF, 16'h0300 + 16'(i), 16'h7000 + 16'(i));
            else up_sel = 1'b0;
            step();
            if (i >= 1) begin
                chk("wr_sel", vram_sel, 1);
                chk("wr_data", vram_data, 32'h7000 + i - 1);
            end
        end
        step();
        chk("wr_end_sel", vram_sel, 0);

        // Reset during REQ with 4 queued
        vram_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 4'hF, 16'h0400 + 16'(i), 16'h4000 + 16'(i));
            step();
        end
        up_sel = 1'b0;
        chk("rr_level_pre", level, 4);
        chk("rr_sel_pre", vram_sel, 1);
        #2 reset_ni = 1'b0;
        #1;
        chk("rr_sel", vram_sel, 0);
        chk("rr_level", level, 0);
        chk("rr_addr", vram_addr, 0);
        chk("rr_empty", empty, 1);
        chk("rr_ready", up_ready, 1);
        step();
        reset_ni = 1'b1;
        vram_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_quiet", vram_sel, 0);
        end

        // Two writes to 0x0020 behind a stalled request
        vram_ack = 1'b0;
        offer(1'b1, 4'hF, 16'h0040, 16'h4444);
        step();
        offer(1'b1, 4'h3, 16'h0020, 16'h00AA);
        step();
        offer(1'b1, 4'hC, 16'h0020, 16'hBB00);
        step();
        up_sel = 1'b0;
        chk("mg_blocker", vram_addr, 16'h0040);
`ifdef VRAM_WR_MERGE_EN
        chk("mg_level", level, 1);
`else
        chk("mg_level", level, 2);
`endif
        vram_ack = 1'b1;
        step();
        chk("mg_addr", vram_addr, 16'h0020);
`ifdef VRAM_WR_MERGE_EN
        chk("mg_mask", vram_mask, 4'hF);
        chk("mg_data", vram_data, 16'hBBAA);
        step();
        chk("mg_end_sel", vram_sel, 0);
`else
        chk("mg_mask_a", vram_mask, 4'h3);
        chk("mg_data_a", vram_data, 16'h00AA);
        step();
        chk("mg_addr_b", vram_addr, 16'h0020);
        chk("mg_mask_b", vram_mask, 4'hC);
        chk("mg_data_b", vram_data, 16'hBB00);
        step();
        chk("mg_end_sel", vram_sel, 0);
`endif
        chk("mg_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
